// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if
//   Bundles the button-side signals of btn_conditioner.
//   master: the block that owns the raw pins and consumes the conditioned results
//           (game top level or testbench).
//   slave:  the conditioner itself.
//   Signals (all N_BTN wide unless noted):
//     btn_raw      raw active-high button pins
//     btn_level    debounced level
//     btn_press    1-cycle accepted press / auto-repeat strobe
//     btn_release  1-cycle accepted release strobe
//     any_press    (1 bit) OR of btn_press, one cycle later
interface btn_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Conditions raw push-button pins for the game controller. Every channel is
//   independent: a 2-FF synchronizer feeds a per-channel debounce FSM that
//   produces a registered level, 1-cycle press/release strobes and optional
//   auto-repeat press strobes while a button is held.
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    btn_conditioner_if.slave: btn_raw in; btn_level, btn_press,
//          btn_release, any_press out (all registered)
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic             clk,
  input  logic             reset,
  btn_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // Parameter sanity, caught at elaboration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_count
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end
  if ($clog2(MAX_CNT + 1) > CNT_W) begin : g_bad_cnt_w
    $error("btn_conditioner: CNT_W too narrow for the largest count");
  end

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic             any_q;

  state_t           state     [N_BTN];
  logic [CNT_W-1:0] dcnt      [N_BTN];
  logic [CNT_W-1:0] rcnt      [N_BTN];
  // 0: waiting out REPEAT_DELAY after the accepted press; 1: repeating at REPEAT_RATE.
  logic             rep_phase [N_BTN];

  // Synchronizer, per-channel FSMs and all registered outputs. Strobes default
  // low every cycle so they can only be high for the single cycle they are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]     <= RELEASED;
        dcnt[i]      <= '0;
        rcnt[i]      <= '0;
        rep_phase[i] <= 1'b0;
      end
    end else begin
      sync1     <= bus.btn_raw;
      sync2     <= sync1;
      any_q     <= |press_q;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          RELEASED: begin
            if (sync2[i]) begin
              state[i] <= PRESS_PEND;
              dcnt[i]  <= '0;
            end
          end
          PRESS_PEND: begin
            if (!sync2[i]) begin
              state[i] <= RELEASED;
            end else if (dcnt[i] == DEB_LAST) begin
              state[i]     <= PRESSED;
              level_q[i]   <= 1'b1;
              press_q[i]   <= 1'b1;
              dcnt[i]      <= '0;
              rcnt[i]      <= '0;
              rep_phase[i] <= 1'b0;
            end else begin
              dcnt[i] <= dcnt[i] + 1'b1;
            end
          end
          PRESSED: begin
            if (!sync2[i]) begin
              state[i] <= RELEASE_PEND;
              dcnt[i]  <= '0;
            end else if (REPEAT_EN != 0) begin
              if (rcnt[i] == (rep_phase[i] ? RATE_LAST : DELAY_LAST)) begin
                press_q[i]   <= 1'b1;
                rcnt[i]      <= '0;
                rep_phase[i] <= 1'b1;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
          end
          RELEASE_PEND: begin
            // A bounce back high keeps the repeat phase but restarts its count.
            if (sync2[i]) begin
              state[i] <= PRESSED;
              rcnt[i]  <= '0;
            end else if (dcnt[i] == DEB_LAST) begin
              state[i]     <= RELEASED;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
              dcnt[i]      <= '0;
            end else begin
              dcnt[i] <= dcnt[i] + 1'b1;
            end
          end
          default: state[i] <= RELEASED;
        endcase
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//   Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_RATE=3, N_BTN=4. Stimulus records expected output
//   events (by clock-edge number) into a scoreboard queue; a negedge monitor
//   compares every cycle against the queue head or the quiet-state default.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(4)) bus ();

  btn_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
  } exp_t;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
    logic [3:0] exp_level;
  } vec_t;

  exp_t       sb_q[$];
  int         cyc        = 0;
  logic [3:0] exp_level  = 4'b0000;
  bit         mon_enable = 1'b0;
  int         checks     = 0;
  int         passed     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [3:0] lv, input logic [3:0] pr,
                             input logic [3:0] rl, input logic an);
    checks++;
    if (bus.btn_level === lv && bus.btn_press === pr && bus.btn_release === rl && bus.any_press === an) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: level/press/release/any got %b/%b/%b/%b expected %b/%b/%b/%b",
               name, bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press, lv, pr, rl, an);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic [3:0] lv, input logic [3:0] pr,
                          input logic [3:0] rl, input logic an);
    exp_t e;
    e.cyc   = c;
    e.level = lv;
    e.press = pr;
    e.rel   = rl;
    e.any   = an;
    sb_q.push_back(e);
  endtask

  // Drives one table row at the current edge P: accepted changes strobe on edge
  // P+7, with any_press following on P+8.
  task automatic applyStimulus(input vec_t v);
    int p;
    p = cyc;
    bus.btn_raw = v.raw;
    if (v.exp_press != 4'b0000 || v.exp_rel != 4'b0000)
      push_exp(p + 7, v.exp_level, v.exp_press, v.exp_rel, 1'b0);
    if (v.exp_press != 4'b0000)
      push_exp(p + 8, v.exp_level, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(v.hold);
  endtask

  // Per-cycle monitor: outside scheduled events, strobes must be low and the
  // level must hold its last expected value.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_enable) begin
      e.cyc   = cyc;
      e.level = exp_level;
      e.press = 4'b0000;
      e.rel   = 4'b0000;
      e.any   = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        checks++;
        $display("[TB] FAIL sb_stale: event for cycle %0d still queued at cycle %0d", sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        exp_level = e.level;
      end
      checkOutput($sformatf("cyc%0d", cyc), e.level, e.press, e.rel, e.any);
    end
  end

  initial begin : stimulus
    vec_t vecs[6];
    int   p;

    vecs[0] = '{raw: 4'b0001, hold: 10, exp_press: 4'b0001, exp_rel: 4'b0000, exp_level: 4'b0001};
    vecs[1] = '{raw: 4'b0000, hold: 10, exp_press: 4'b0000, exp_rel: 4'b0001, exp_level: 4'b0000};
    vecs[2] = '{raw: 4'b0010, hold: 3,  exp_press: 4'b0000, exp_rel: 4'b0000, exp_level: 4'b0000};
    vecs[3] = '{raw: 4'b0000, hold: 10, exp_press: 4'b0000, exp_rel: 4'b0000, exp_level: 4'b0000};
    vecs[4] = '{raw: 4'b1001, hold: 10, exp_press: 4'b1001, exp_rel: 4'b0000, exp_level: 4'b1001};
    vecs[5] = '{raw: 4'b0000, hold: 10, exp_press: 4'b0000, exp_rel: 4'b1001, exp_level: 4'b0000};

    reset       = 1'b1;
    bus.btn_raw = 4'b0000;
    wait_cycles(3);
    checkOutput("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset      = 1'b0;
    mon_enable = 1'b1;
    wait_cycles(2);

    // Reset while all buttons are held, then release reset with them still held.
    p = cyc;
    bus.btn_raw = 4'b1111;
    push_exp(p + 7, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    push_exp(p + 8, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(10);
    #2;
    mon_enable = 1'b0;
    reset      = 1'b1;
    #1;
    checkOutput("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    exp_level = 4'b0000;
    wait_cycles(1);
    checkOutput("reset_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset      = 1'b0;
    mon_enable = 1'b1;
    p = cyc;
    push_exp(p + 7, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    push_exp(p + 8, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(10);
    p = cyc;
    bus.btn_raw = 4'b0000;
    push_exp(p + 7, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    wait_cycles(10);

    // Clean press/release, glitch rejection, simultaneous press/release.
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Hold channel 2: press, first repeat after REPEAT_DELAY, then every REPEAT_RATE.
    p = cyc;
    bus.btn_raw = 4'b0100;
    push_exp(p + 7,  4'b0100, 4'b0100, 4'b0000, 1'b0);
    push_exp(p + 8,  4'b0100, 4'b0000, 4'b0000, 1'b1);
    push_exp(p + 17, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    push_exp(p + 18, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    push_exp(p + 20, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    push_exp(p + 21, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    push_exp(p + 23, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    push_exp(p + 24, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(22);
    p = cyc;
    bus.btn_raw = 4'b0000;
    push_exp(p + 7, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    wait_cycles(12);

    // Channel 3 bounces on release; only the final stable low is accepted.
    p = cyc;
    bus.btn_raw = 4'b1000;
    push_exp(p + 7, 4'b1000, 4'b1000, 4'b0000, 1'b0);
    push_exp(p + 8, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(10);
    bus.btn_raw = 4'b0000;
    wait_cycles(2);
    bus.btn_raw = 4'b1000;
    wait_cycles(2);
    p = cyc;
    bus.btn_raw = 4'b0000;
    push_exp(p + 7, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    wait_cycles(12);

    mon_enable = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin
      passed++;
    end else begin
      $display("[TB] FAIL sb_drain: %0d events left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
